// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB full-speed transmit path.
package usb_tx_pkg;

    localparam int DEF_CLKS_PER_BIT = 8;

    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        STUFF,
        EOP_SE0,
        EOP_J,
        DONE
    } tx_enc_state_t;

    // NRZI: a 0 toggles between J and K, a 1 holds the current level.
    function automatic logic [1:0] nrzi_next(input logic [1:0] line, input logic bit_val);
        return bit_val ? line : ((line == LINE_J) ? LINE_K : LINE_J);
    endfunction

endpackage

// File: rtl/tx_encoder_if.sv
// Buffer, timer and line signals of the TX encoder, bundled for the encoder ports.
interface tx_encoder_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       last_byte;
    logic       bit_strobe;
    logic       timer_enable;
    logic       get_byte;
    logic       dplus_out;
    logic       dminus_out;
    logic       tx_transmitting;
    logic       tx_done;

    modport master (
        output tx_start, tx_data, last_byte, bit_strobe,
        input  timer_enable, get_byte, dplus_out, dminus_out, tx_transmitting, tx_done
    );

    modport slave (
        input  tx_start, tx_data, last_byte, bit_strobe,
        output timer_enable, get_byte, dplus_out, dminus_out, tx_transmitting, tx_done
    );
endinterface

// File: rtl/tx_bit_stuffer.sv
// Counts consecutive 1 data bits and runs the one-bit-period stall for a stuffed 0.
module tx_bit_stuffer #(
    parameter int CLKS_PER_BIT = 8,
    parameter int STUFF_LIMIT  = 6
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic bit_done,
    input  logic bit_val,
    output logic stuff_req,
    output logic stall_active,
    output logic stall_done
);
    localparam int OW = $clog2(STUFF_LIMIT + 1);
    localparam int SW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [OW-1:0] ONES_MAX   = OW'(STUFF_LIMIT);
    localparam logic [OW-1:0] ONES_TRIG  = OW'(STUFF_LIMIT - 1);
    localparam logic [SW-1:0] STALL_LAST = SW'(CLKS_PER_BIT - 1);

    logic [OW-1:0] ones_cnt;
    logic [SW-1:0] stall_cnt;

    assign stuff_req  = bit_done && bit_val && (ones_cnt == ONES_TRIG);
    assign stall_done = stall_active && (stall_cnt == STALL_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ones_cnt     <= '0;
            stall_cnt    <= '0;
            stall_active <= 1'b0;
        end else if (clear) begin
            ones_cnt     <= '0;
            stall_cnt    <= '0;
            stall_active <= 1'b0;
        end else begin
            if (bit_done) begin
                if (stuff_req || !bit_val) begin
                    ones_cnt <= '0;
                end else if (ones_cnt != ONES_MAX) begin
                    ones_cnt <= ones_cnt + 1'b1;
                end
            end
            if (stuff_req) begin
                stall_active <= 1'b1;
                stall_cnt    <= '0;
            end else if (stall_active) begin
                stall_active <= !stall_done;
                stall_cnt    <= stall_done ? '0 : stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_encoder.sv
// USB full-speed TX encoder: LSB-first serialiser, bit stuffing, NRZI line drive and EOP.
module tx_encoder
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int STUFF_LIMIT  = 6,
    parameter int EOP_SE0_BITS = 2
) (
    input  logic         clk,
    input  logic         n_rst,
    tx_encoder_if.slave  bus
);
    localparam int EW = (EOP_SE0_BITS > 1) ? $clog2(EOP_SE0_BITS) : 1;
    localparam logic [EW-1:0] EOP_LAST = EW'(EOP_SE0_BITS - 1);

    tx_enc_state_t state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic          last_q, last_d;
    logic [1:0]    line_q, line_d;
    logic          ten_q, ten_d;
    logic          xmit_q, xmit_d;
    logic          done_q, done_d;
    logic [EW-1:0] eop_q, eop_d;

    logic get_byte, advance, stuffer_clear;
    logic bit_done, stuff_req, stall_active, stall_done;

    assign bit_done = (state_q == SEND) && bus.bit_strobe;

    tx_bit_stuffer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .STUFF_LIMIT  (STUFF_LIMIT)
    ) u_stuffer (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (stuffer_clear),
        .bit_done     (bit_done),
        .bit_val      (shift_q[0]),
        .stuff_req    (stuff_req),
        .stall_active (stall_active),
        .stall_done   (stall_done)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            last_q    <= 1'b0;
            line_q    <= LINE_J;
            ten_q     <= 1'b0;
            xmit_q    <= 1'b0;
            done_q    <= 1'b0;
            eop_q     <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            last_q    <= last_d;
            line_q    <= line_d;
            ten_q     <= ten_d;
            xmit_q    <= xmit_d;
            done_q    <= done_d;
            eop_q     <= eop_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bit_idx_d     = bit_idx_q;
        last_d        = last_q;
        line_d        = line_q;
        ten_d         = ten_q;
        xmit_d        = xmit_q;
        done_d        = 1'b0;
        eop_d         = eop_q;
        get_byte      = 1'b0;
        advance       = 1'b0;
        stuffer_clear = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.tx_start) begin
                    get_byte      = 1'b1;
                    stuffer_clear = 1'b1;
                    shift_d       = bus.tx_data;
                    last_d        = bus.last_byte;
                    bit_idx_d     = '0;
                    line_d        = nrzi_next(LINE_J, bus.tx_data[0]);
                    ten_d         = 1'b1;
                    xmit_d        = 1'b1;
                    state_d       = SEND;
                end
            end
            SEND: begin
                if (bus.bit_strobe) begin
                    if (stuff_req) begin
                        state_d = STUFF;
                        line_d  = nrzi_next(line_q, 1'b0);
                        ten_d   = 1'b0;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            STUFF: begin
                if (stall_done) begin
                    advance = 1'b1;
                    ten_d   = 1'b1;
                end
            end
            EOP_SE0: begin
                if (bus.bit_strobe) begin
                    if (eop_q == EOP_LAST) begin
                        state_d = EOP_J;
                        line_d  = LINE_J;
                    end else begin
                        eop_d = eop_q + 1'b1;
                    end
                end
            end
            EOP_J: begin
                if (bus.bit_strobe) begin
                    ten_d   = 1'b0;
                    xmit_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Move past the finished bit (or the stuffed 0 that followed it).
        if (advance) begin
            if (bit_idx_q == 3'd7) begin
                if (last_q) begin
                    state_d = EOP_SE0;
                    line_d  = LINE_SE0;
                    eop_d   = '0;
                end else begin
                    get_byte  = 1'b1;
                    shift_d   = bus.tx_data;
                    last_d    = bus.last_byte;
                    bit_idx_d = '0;
                    line_d    = nrzi_next(line_q, bus.tx_data[0]);
                    state_d   = SEND;
                end
            end else begin
                shift_d   = {1'b0, shift_q[7:1]};
                bit_idx_d = bit_idx_q + 3'd1;
                line_d    = nrzi_next(line_q, shift_q[1]);
                state_d   = SEND;
            end
        end
    end

    assign bus.get_byte        = get_byte;
    assign bus.timer_enable    = ten_q;
    assign bus.dplus_out       = line_q[1];
    assign bus.dminus_out      = line_q[0];
    assign bus.tx_transmitting = xmit_q;
    assign bus.tx_done         = done_q;

    // The timer is frozen while stuffing, so a strobe here means tx_timer is out of step.
    a_no_strobe_in_stuff: assert property (
        @(posedge clk) disable iff (!n_rst) !((state_q == STUFF) && bus.bit_strobe));
    a_stall_tracks_state: assert property (
        @(posedge clk) disable iff (!n_rst) ((state_q == STUFF) == stall_active));

endmodule

// File: tb/tb_tx_encoder.sv
// Directed bench for tx_encoder with an 8 clk/bit tx_timer model and a byte-buffer model.
module tb_tx_encoder;
    import usb_tx_pkg::*;

    localparam int BUDGET = 2000;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    tx_encoder_if bus ();

    tx_encoder #(.CLKS_PER_BIT(8), .STUFF_LIMIT(6), .EOP_SE0_BITS(2)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    // tx_timer model: strobe on the last enabled clock of each 8-clock bit period.
    logic [2:0] tmr_cnt;
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) tmr_cnt <= 3'd0;
        else if (bus.timer_enable) tmr_cnt <= tmr_cnt + 3'd1;
    end
    assign bus.bit_strobe = bus.timer_enable && (tmr_cnt == 3'd7);

    // TX buffer model: advances after each get_byte.
    logic [7:0] pkt [0:3];
    int         pkt_len = 1;
    logic       buf_clear = 1'b1;
    int         ptr = 0;
    always @(posedge clk) begin
        if (buf_clear) ptr <= 0;
        else if (bus.get_byte) ptr <= ptr + 1;
    end
    assign bus.tx_data   = (ptr < 4) ? pkt[ptr[1:0]] : 8'h00;
    assign bus.last_byte = (ptr == pkt_len - 1);

    int checks = 0;
    int failures = 0;

    logic [1:0] exp_sym[$];
    bit         exp_te[$];
    logic [1:0] tr_line[$];
    bit         tr_te[$];
    bit         tr_tx[$];
    int         gb_total, gb_on_strobe, done_at;

    task automatic load_packet(input int len, input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2);
        pkt[0] = b0; pkt[1] = b1; pkt[2] = b2; pkt[3] = 8'h00;
        pkt_len   = len;
        buf_clear = 1'b1;
        @(posedge clk);
        #1 buf_clear = 1'b0;
    endtask

    // Independent reference: NRZI from J, stuffed 0 after six 1s, then SE0 SE0 J.
    task automatic build_expected();
        logic [1:0] ln;
        int         ones;
        logic       bv;
        ln = LINE_J;
        ones = 0;
        exp_sym.delete();
        exp_te.delete();
        for (int b = 0; b < pkt_len; b++) begin
            for (int i = 0; i < 8; i++) begin
                bv = pkt[b][i];
                if (!bv) ln = ~ln;
                exp_sym.push_back(ln);
                exp_te.push_back(1'b1);
                ones = bv ? ones + 1 : 0;
                if (ones == 6) begin
                    ln = ~ln;
                    exp_sym.push_back(ln);
                    exp_te.push_back(1'b0);
                    ones = 0;
                end
            end
        end
        exp_sym.push_back(LINE_SE0); exp_te.push_back(1'b1);
        exp_sym.push_back(LINE_SE0); exp_te.push_back(1'b1);
        exp_sym.push_back(LINE_J);   exp_te.push_back(1'b1);
    endtask

    // Must be entered between a rising and falling edge (load_packet leaves it there).
    task automatic send_packet(input int glitch_at);
        tr_line.delete(); tr_te.delete(); tr_tx.delete();
        gb_total = 0; gb_on_strobe = 0; done_at = -1;
        bus.tx_start = 1'b1;
        @(negedge clk);
        if (bus.get_byte) gb_total++;
        @(posedge clk);
        #1 bus.tx_start = 1'b0;
        for (int i = 0; i < BUDGET && done_at < 0; i++) begin
            @(negedge clk);
            if (i == glitch_at) bus.tx_start = 1'b1;
            else if (i == glitch_at + 1) bus.tx_start = 1'b0;
            if (bus.get_byte) begin
                gb_total++;
                if (bus.bit_strobe) gb_on_strobe++;
            end
            if (bus.tx_done) begin
                done_at = i;
            end else begin
                tr_line.push_back({bus.dplus_out, bus.dminus_out});
                tr_te.push_back(bus.timer_enable);
                tr_tx.push_back(bus.tx_transmitting);
            end
        end
        bus.tx_start = 1'b0;
    endtask

    function automatic int trace_errors();
        int n;
        n = 0;
        for (int i = 0; i < tr_line.size(); i++) begin
            if (i >= 8 * exp_sym.size()) n++;
            else if (tr_line[i] !== exp_sym[i / 8] || tr_te[i] !== exp_te[i / 8] || tr_tx[i] !== 1'b1) n++;
        end
        if (tr_line.size() < 8 * exp_sym.size()) n += 8 * exp_sym.size() - tr_line.size();
        return n;
    endfunction

    function automatic int te_low_first();
        for (int i = 0; i < tr_te.size(); i++) if (tr_te[i] == 1'b0) return i;
        return -1;
    endfunction

    function automatic int te_low_count();
        int n;
        n = 0;
        for (int i = 0; i < tr_te.size(); i++) if (tr_te[i] == 1'b0) n++;
        return n;
    endfunction

    task automatic test_reset();
        n_rst = 1'b0;
        bus.tx_start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.dplus_out, bus.dminus_out} !== LINE_J) begin
            failures++; $display("FAIL reset_line: got %b, want %b", {bus.dplus_out, bus.dminus_out}, LINE_J);
        end
        checks++;
        if ({bus.timer_enable, bus.get_byte, bus.tx_transmitting, bus.tx_done} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl: got te/gb/tx/done=%b, want 0000",
                     {bus.timer_enable, bus.get_byte, bus.tx_transmitting, bus.tx_done});
        end
        @(posedge clk);
        #1 n_rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.dplus_out, bus.dminus_out, bus.timer_enable, bus.tx_transmitting} !== 4'b1000) begin
            failures++;
            $display("FAIL idle_after_reset: got dp/dm/te/tx=%b, want 1000",
                     {bus.dplus_out, bus.dminus_out, bus.timer_enable, bus.tx_transmitting});
        end
    endtask

    task automatic test_single_sync();
        load_packet(1, 8'h80, 8'h00, 8'h00);
        exp_sym = {LINE_K, LINE_J, LINE_K, LINE_J, LINE_K, LINE_J, LINE_K, LINE_K,
                   LINE_SE0, LINE_SE0, LINE_J};
        exp_te.delete();
        for (int i = 0; i < 11; i++) exp_te.push_back(1'b1);
        send_packet(-10);
        checks++;
        if (trace_errors() !== 0) begin
            failures++; $display("FAIL sync_wave: got %0d bad samples, want 0", trace_errors());
        end
        checks++;
        if (done_at !== 88) begin
            failures++; $display("FAIL sync_done_time: got %0d, want 88", done_at);
        end
        checks++;
        if (gb_total !== 1) begin
            failures++; $display("FAIL sync_get_byte: got %0d pulses, want 1", gb_total);
        end
        checks++;
        if (bus.tx_transmitting !== 1'b0) begin
            failures++; $display("FAIL sync_xmit_at_done: got %b, want 0", bus.tx_transmitting);
        end
        @(negedge clk);
        checks++;
        if ({bus.tx_done, bus.dplus_out, bus.dminus_out} !== 3'b010) begin
            failures++; $display("FAIL sync_after_done: got done/dp/dm=%b, want 010",
                                 {bus.tx_done, bus.dplus_out, bus.dminus_out});
        end
    endtask

    task automatic test_stuff_mid();
        load_packet(2, 8'h80, 8'hFF, 8'h00);
        build_expected();
        send_packet(-10);
        checks++;
        if (trace_errors() !== 0) begin
            failures++; $display("FAIL stuff_mid_wave: got %0d bad samples, want 0", trace_errors());
        end
        checks++;
        if (done_at !== 160) begin
            failures++; $display("FAIL stuff_mid_done_time: got %0d, want 160", done_at);
        end
        checks++;
        if (te_low_first() !== 104 || te_low_count() !== 8) begin
            failures++; $display("FAIL stuff_mid_stall: got first=%0d count=%0d, want first=104 count=8",
                                 te_low_first(), te_low_count());
        end
    endtask

    task automatic test_stuff_end();
        load_packet(2, 8'h80, 8'hFC, 8'h00);
        build_expected();
        send_packet(-10);
        checks++;
        if (trace_errors() !== 0) begin
            failures++; $display("FAIL stuff_end_wave: got %0d bad samples, want 0", trace_errors());
        end
        checks++;
        if (done_at !== 160 || te_low_first() !== 128 || te_low_count() !== 8) begin
            failures++; $display("FAIL stuff_end_timing: got done=%0d first=%0d count=%0d, want 160 128 8",
                                 done_at, te_low_first(), te_low_count());
        end
        // The 1 ending the SYNC byte counts toward the run in the next byte.
        load_packet(2, 8'h80, 8'h3F, 8'h00);
        build_expected();
        send_packet(-10);
        checks++;
        if (trace_errors() !== 0 || te_low_first() !== 104 || done_at !== 160) begin
            failures++; $display("FAIL stuff_carry: got bad=%0d first=%0d done=%0d, want 0 104 160",
                                 trace_errors(), te_low_first(), done_at);
        end
    endtask

    task automatic test_multi_byte();
        logic [23:0] dec;
        logic [1:0]  prev;
        load_packet(3, 8'h80, 8'hA5, 8'h5A);
        build_expected();
        send_packet(-10);
        checks++;
        if (trace_errors() !== 0 || done_at !== 216) begin
            failures++; $display("FAIL multi_wave: got bad=%0d done=%0d, want 0 216", trace_errors(), done_at);
        end
        checks++;
        if (gb_total !== 3 || gb_on_strobe !== 2) begin
            failures++; $display("FAIL multi_get_byte: got total=%0d on_strobe=%0d, want 3 2",
                                 gb_total, gb_on_strobe);
        end
        dec = 24'h0;
        prev = LINE_J;
        for (int k = 0; k < 24; k++) begin
            if (tr_line.size() > 8 * k + 4) begin
                dec[k] = (tr_line[8 * k + 4] == prev);
                prev = tr_line[8 * k + 4];
            end
        end
        checks++;
        if (dec !== 24'h5AA580) begin
            failures++; $display("FAIL multi_decode: got %h, want 5aa580", dec);
        end
    endtask

    task automatic test_ignore_start();
        load_packet(3, 8'h80, 8'hA5, 8'h5A);
        build_expected();
        send_packet(50);
        checks++;
        if (trace_errors() !== 0 || done_at !== 216 || gb_total !== 3) begin
            failures++; $display("FAIL ignore_start: got bad=%0d done=%0d gb=%0d, want 0 216 3",
                                 trace_errors(), done_at, gb_total);
        end
    endtask

    task automatic test_reset_mid_packet();
        load_packet(2, 8'h80, 8'hFF, 8'h00);
        bus.tx_start = 1'b1;
        @(posedge clk);
        #1 bus.tx_start = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if ({bus.dplus_out, bus.dminus_out, bus.timer_enable, bus.tx_transmitting} !== 4'b0111) begin
            failures++; $display("FAIL pre_reset: got dp/dm/te/tx=%b, want 0111",
                                 {bus.dplus_out, bus.dminus_out, bus.timer_enable, bus.tx_transmitting});
        end
        n_rst = 1'b0;
        #1;
        checks++;
        if ({bus.dplus_out, bus.dminus_out, bus.timer_enable, bus.tx_transmitting} !== 4'b1000) begin
            failures++; $display("FAIL mid_reset: got dp/dm/te/tx=%b, want 1000",
                                 {bus.dplus_out, bus.dminus_out, bus.timer_enable, bus.tx_transmitting});
        end
        @(posedge clk);
        #1 n_rst = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if ({bus.dplus_out, bus.dminus_out, bus.timer_enable, bus.tx_done} !== 4'b1000) begin
            failures++; $display("FAIL no_eop_after_reset: got dp/dm/te/done=%b, want 1000",
                                 {bus.dplus_out, bus.dminus_out, bus.timer_enable, bus.tx_done});
        end
    endtask

    task automatic test_back_to_back();
        load_packet(2, 8'h80, 8'hF8, 8'h00);
        build_expected();
        send_packet(-10);
        checks++;
        if (trace_errors() !== 0 || done_at !== 152) begin
            failures++; $display("FAIL b2b_first: got bad=%0d done=%0d, want 0 152", trace_errors(), done_at);
        end
        // Still in the tx_done cycle: the next start lands on the following cycle.
        load_packet(1, 8'h3F, 8'h00, 8'h00);
        build_expected();
        send_packet(-10);
        checks++;
        if (trace_errors() !== 0 || done_at !== 96) begin
            failures++; $display("FAIL b2b_second: got bad=%0d done=%0d, want 0 96", trace_errors(), done_at);
        end
        checks++;
        if (te_low_first() !== 48 || gb_total !== 1) begin
            failures++; $display("FAIL b2b_ones_clear: got stall_at=%0d gb=%0d, want 48 1",
                                 te_low_first(), gb_total);
        end
    endtask

    initial begin
        test_reset();
        test_single_sync();
        test_stuff_mid();
        test_stuff_end();
        test_multi_byte();
        test_ignore_start();
        test_reset_mid_packet();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
